decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I decode stage sitting directly downstream of `fetch`.
- Accepts {pc, instruction} beats from fetch over a valid/ready handshake and decodes them into register indices, a sign-extended immediate, funct fields and an operation class.
- Presents the result to execute through a registered valid/ready interface.
- Contains a 2-entry skid buffer, so `f_ready` is a pure register output and back-to-back throughput is one instruction per cycle.
- Honours the same `c_flush` control that fetch receives.

Parameters:
- XLEN, 32, data/PC width. Only 32 is supported.

Ports:
- clk  in  1  single clock domain, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_flush  in  1  pipeline flush; discards all buffered and incoming beats.
- f_valid  in  1  fetch beat valid.
- f_ready  out  1  decode can accept a beat; registered.
- f_pc  in  XLEN  PC of the fetched instruction.
- f_instr  in  32  raw instruction word.
- d_valid  out  1  decoded beat valid.
- d_ready  in  1  execute accepts the beat.
- d_pc  out  XLEN  PC passed through.
- d_class  out  4  op class: 0 ILLEGAL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OPIMM, 9 OP, 10 FENCE, 11 SYSTEM, 12 MULDIV.
- d_rd, d_rs1, d_rs2  out  5 each  register indices.
- d_funct3  out  3  instr[14:12].
- d_funct7b5  out  1  instr[30].
- d_imm  out  XLEN  sign-extended immediate; I/S/B/U/J format selected by class, 0 for OP/MULDIV/ILLEGAL.
- d_illegal  out  1  illegal-instruction flag.

Behaviour:
- Reset (async, rst_n=0): all d_* outputs = 0; f_ready = 1; occupancy = EMPTY.
- Decode is combinational on f_instr. Results are captured into the main register on accept (f_valid & f_ready). Latency is 1 cycle: accept at edge N, so d_valid=1 after edge N.
- Occupancy FSM. `take` = d_valid & d_ready; `acc` = f_valid & f_ready.
  - EMPTY: acc → ONE.
  - ONE: acc & !take → TWO, with the new beat stored in the skid register. acc & take → ONE, with the main register reloaded. take & !acc → EMPTY.
  - TWO: f_ready = 0. take → ONE, with skid moved to main.
- f_ready is registered: f_ready = (next state != TWO).
- d_* outputs hold stable while d_valid=1 and d_ready=0.
- Beat order is strictly preserved; no beat is dropped or duplicated.
- Flush: c_flush=1 at an edge forces EMPTY and d_valid=0 after that edge, and makes f_ready=1.
  - A beat offered in the same cycle as c_flush is discarded, even if f_ready=1.
  - Flush has priority over acc and take.
- Illegal-instruction cases, each giving d_class=0, d_illegal=1, d_rd=0, d_imm=0:
  - instr[1:0] != 2'b11.
  - Unknown opcode.
  - BRANCH with funct3 of 2 or 3.
  - LOAD with funct3 of 3, 6 or 7.
  - STORE with funct3 > 2.
  - JALR with funct3 != 0.
  - OPIMM shift where funct7 is not 0x00, or not 0x20 for SRAI.
  - OP with funct7 not in {0x00, 0x20}, or 0x20 used with funct3 other than 0 or 5.
- Illegal beats still flow through the handshake normally.
- For STORE and BRANCH, d_rd = 0.
- Immediate sign bit is always instr[31].

Optional Feature:
- Macro: DECODE_RV32M_EN.
- Defined: OP opcode with funct7=0x01 decodes as class 12 (MULDIV), d_illegal=0, d_imm=0.
- Not defined: that encoding is illegal (class 0, d_illegal=1). The MULDIV code is reserved and never emitted.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants (OPC_LUI=7'h37, OPC_AUIPC=7'h17, OPC_JAL=7'h6F, OPC_JALR=7'h67, OPC_BRANCH=7'h63, OPC_LOAD=7'h03, OPC_STORE=7'h23, OPC_OPIMM=7'h13, OPC_OP=7'h33, OPC_FENCE=7'h0F, OPC_SYSTEM=7'h73).
  - The 4-bit op-class enum.
- One combinational sub-module, decode_imm_gen: instruction + class → 32-bit immediate.
- The FSM and skid registers stay in decode_stage.

Test Plan:
- addi x1,x0,5: f_instr=0x00500093, f_pc=0x100, d_ready=1 → one cycle later d_valid=1, class=8, rd=1, rs1=0, imm=0x00000005, d_pc=0x100.
- beq x0,x0,-4: f_instr=0xFE000EE3 → class=5, rd=0, imm=0xFFFFFFFC, funct3=0.
- Backpressure: stream 6 beats with f_valid=1 and d_ready=0 for 3 cycles.
  - f_ready falls after 2 accepts.
  - After d_ready=1, all 6 beats are delivered in PC order with no gaps or duplicates.
- Flush in TWO: fill both entries, assert c_flush for 1 cycle with f_valid=1 → next cycle d_valid=0, f_ready=1; the concurrent beat never appears.
- Illegal: f_instr=0x00000000 and f_instr=0x00003003 (LD) → d_illegal=1, class=0, rd=0, beat still handshakes.
- mul x0,x1,x2 (0x02208033) → class=12, d_illegal=0 with DECODE_RV32M_EN; class=0, d_illegal=1 without it.
- Async reset mid-stream: drop rst_n while in TWO → outputs go 0 and f_ready goes 1 immediately, without waiting for clk.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, op-class codes,
// the decoded-beat payload and the decode-stage occupancy states.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    // MULDIV is only produced when the M extension is built in.
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_LUI     = 4'd1,
        CLS_AUIPC   = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_JALR    = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LOAD    = 4'd6,
        CLS_STORE   = 4'd7,
        CLS_OPIMM   = 4'd8,
        CLS_OP      = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_SYSTEM  = 4'd11,
        CLS_MULDIV  = 4'd12
    } op_class_e;

    typedef struct packed {
        op_class_e   cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] imm;
        logic        illegal;
    } dec_fields_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch->decode and decode->execute handshake bundle.
// master: the surrounding pipeline (fetch drives f_*, execute drives d_ready).
// slave:  the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
    logic             f_valid;
    logic             f_ready;
    logic [XLEN-1:0]  f_pc;
    logic [31:0]      f_instr;

    logic             d_valid;
    logic             d_ready;
    logic [XLEN-1:0]  d_pc;
    logic [3:0]       d_class;
    logic [4:0]       d_rd;
    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic [2:0]       d_funct3;
    logic             d_funct7b5;
    logic [XLEN-1:0]  d_imm;
    logic             d_illegal;

    modport master (
        output f_valid, f_pc, f_instr, d_ready,
        input  f_ready, d_valid, d_pc, d_class, d_rd, d_rs1, d_rs2,
               d_funct3, d_funct7b5, d_imm, d_illegal
    );

    modport slave (
        input  f_valid, f_pc, f_instr, d_ready,
        output f_ready, d_valid, d_pc, d_class, d_rd, d_rs1, d_rs2,
               d_funct3, d_funct7b5, d_imm, d_illegal
    );
endinterface

// File: rtl/decode_imm_gen.sv
// Immediate generator: selects I/S/B/U/J format from the op class.
// Only instr[31:7] carries immediate bits; the opcode is not needed here.
module decode_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr_hi,
    input  op_class_e   cls,
    output logic [31:0] imm
);

    // Format select; classes without an immediate read as zero.
    always_comb begin
        imm = '0;
        case (cls)
            CLS_JALR, CLS_LOAD, CLS_OPIMM, CLS_FENCE, CLS_SYSTEM:
                imm = {{20{instr_hi[31]}}, instr_hi[31:20]};
            CLS_STORE:
                imm = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
            CLS_BRANCH:
                imm = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7],
                       instr_hi[30:25], instr_hi[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                imm = {instr_hi[31:12], 12'h000};
            CLS_JAL:
                imm = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                       instr_hi[20], instr_hi[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with a 2-entry skid buffer and registered f_ready.
// Build option: DECODE_RV32M_EN enables decoding of OP/funct7=0x01 as MULDIV;
// without it that encoding is illegal.
//
// state | meaning
// EMPTY | no beat held, d_valid=0
// ONE   | beat in main register, skid free
// TWO   | main and skid both full, f_ready=0
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           c_flush,
    decode_stage_if.slave  bus
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    op_class_e   dec_cls;
    logic [31:0] dec_imm;
    dec_fields_t dec_in;

    dec_fields_t     main_q;
    dec_fields_t     skid_q;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] skid_pc;

    occ_state_e state;
    occ_state_e state_next;
    logic       f_ready_q;
    logic       acc;
    logic       take;
    logic       load_main;
    logic       load_skid;
    logic       skid_to_main;

    assign opcode = bus.f_instr[6:0];
    assign funct3 = bus.f_instr[14:12];
    assign funct7 = bus.f_instr[31:25];

    // Op-class decode including all illegal-encoding filters.
    always_comb begin
        dec_cls = CLS_ILLEGAL;
        case (opcode)
            OPC_LUI:    dec_cls = CLS_LUI;
            OPC_AUIPC:  dec_cls = CLS_AUIPC;
            OPC_JAL:    dec_cls = CLS_JAL;
            OPC_JALR:   if (funct3 == 3'd0) dec_cls = CLS_JALR;
            OPC_BRANCH: if (funct3 != 3'd2 && funct3 != 3'd3) dec_cls = CLS_BRANCH;
            OPC_LOAD:   if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7)
                            dec_cls = CLS_LOAD;
            OPC_STORE:  if (funct3 <= 3'd2) dec_cls = CLS_STORE;
            OPC_OPIMM: begin
                if (funct3 == 3'd1) begin
                    if (funct7 == 7'h00) dec_cls = CLS_OPIMM;
                end else if (funct3 == 3'd5) begin
                    if (funct7 == 7'h00 || funct7 == 7'h20) dec_cls = CLS_OPIMM;
                end else begin
                    dec_cls = CLS_OPIMM;
                end
            end
            OPC_OP: begin
                if (funct7 == 7'h00)
                    dec_cls = CLS_OP;
                else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))
                    dec_cls = CLS_OP;
`ifdef DECODE_RV32M_EN
                else if (funct7 == 7'h01)
                    dec_cls = CLS_MULDIV;
`endif
            end
            OPC_FENCE:  dec_cls = CLS_FENCE;
            OPC_SYSTEM: dec_cls = CLS_SYSTEM;
            default:    dec_cls = CLS_ILLEGAL;
        endcase
        // Compressed/16-bit encodings are not supported.
        if (bus.f_instr[1:0] != 2'b11) dec_cls = CLS_ILLEGAL;
    end

    decode_imm_gen u_imm_gen (
        .instr_hi (bus.f_instr[31:7]),
        .cls      (dec_cls),
        .imm      (dec_imm)
    );

    // Assemble the decoded payload; no destination for stores, branches or illegals.
    always_comb begin
        dec_in          = '0;
        dec_in.cls      = dec_cls;
        dec_in.illegal  = (dec_cls == CLS_ILLEGAL);
        dec_in.rd       = (dec_cls == CLS_ILLEGAL || dec_cls == CLS_BRANCH ||
                           dec_cls == CLS_STORE) ? 5'd0 : bus.f_instr[11:7];
        dec_in.rs1      = bus.f_instr[19:15];
        dec_in.rs2      = bus.f_instr[24:20];
        dec_in.funct3   = funct3;
        dec_in.funct7b5 = bus.f_instr[30];
        dec_in.imm      = dec_imm;
    end

    assign acc  = bus.f_valid & f_ready_q;
    assign take = (state != OCC_EMPTY) & bus.d_ready;

    // Occupancy next-state and buffer-move controls; flush overrides everything.
    always_comb begin
        state_next   = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (c_flush) begin
            state_next = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (acc) begin
                        state_next = OCC_ONE;
                        load_main  = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (acc && !take) begin
                        state_next = OCC_TWO;
                        load_skid  = 1'b1;
                    end else if (acc && take) begin
                        load_main  = 1'b1;
                    end else if (take) begin
                        state_next = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (take) begin
                        state_next   = OCC_ONE;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_next = OCC_EMPTY;
            endcase
        end
    end

    // State register; f_ready is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OCC_EMPTY;
            f_ready_q <= 1'b1;
        end else begin
            state     <= state_next;
            f_ready_q <= (state_next != OCC_TWO);
        end
    end

    // Main register: loaded from decode or refilled from the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q  <= '0;
            main_pc <= '0;
        end else if (load_main) begin
            main_q  <= dec_in;
            main_pc <= bus.f_pc;
        end else if (skid_to_main) begin
            main_q  <= skid_q;
            main_pc <= skid_pc;
        end
    end

    // Skid register: catches the beat accepted while execute is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q  <= '0;
            skid_pc <= '0;
        end else if (load_skid) begin
            skid_q  <= dec_in;
            skid_pc <= bus.f_pc;
        end
    end

    assign bus.f_ready    = f_ready_q;
    assign bus.d_valid    = (state != OCC_EMPTY);
    assign bus.d_pc       = main_pc;
    assign bus.d_class    = main_q.cls;
    assign bus.d_rd       = main_q.rd;
    assign bus.d_rs1      = main_q.rs1;
    assign bus.d_rs2      = main_q.rs2;
    assign bus.d_funct3   = main_q.funct3;
    assign bus.d_funct7b5 = main_q.funct7b5;
    assign bus.d_imm      = main_q.imm;
    assign bus.d_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: accepted beats push a reference-model
// result, delivered beats pop and compare.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic c_flush = 1'b0;

    decode_stage_if bus ();

    decode_stage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .c_flush (c_flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef DECODE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
        logic        ill;
    } beat_t;

    beat_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int acc_count = 0;
    int take_count = 0;
    bit acc_flag = 0;
    bit rand_ready = 0;
    bit hold = 0;
    beat_t held;
    logic [31:0] pc_next = 32'h100;

    // Reference decode written from the ISA rules with plain arithmetic.
    function automatic beat_t model(input logic [31:0] ins, input logic [31:0] pc);
        beat_t b;
        int op, f3, f7, cls;
        logic signed [31:0] s, hi20, hi25, sgn;
        logic [31:0] imm;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        cls = 0;
        if (ins[1:0] == 2'b11) begin
            case (op)
                'h37: cls = 1;
                'h17: cls = 2;
                'h6F: cls = 3;
                'h67: cls = (f3 == 0) ? 4 : 0;
                'h63: cls = (f3 == 2 || f3 == 3) ? 0 : 5;
                'h03: cls = (f3 == 3 || f3 >= 6) ? 0 : 6;
                'h23: cls = (f3 > 2) ? 0 : 7;
                'h13: begin
                    if (f3 == 1)      cls = (f7 == 0) ? 8 : 0;
                    else if (f3 == 5) cls = (f7 == 0 || f7 == 'h20) ? 8 : 0;
                    else              cls = 8;
                end
                'h33: begin
                    if (f7 == 0)          cls = 9;
                    else if (f7 == 'h20)  cls = (f3 == 0 || f3 == 5) ? 9 : 0;
                    else if (f7 == 1)     cls = M_EN ? 12 : 0;
                    else                  cls = 0;
                end
                'h0F: cls = 10;
                'h73: cls = 11;
                default: cls = 0;
            endcase
        end
        s    = ins;
        hi20 = s >>> 20;
        hi25 = s >>> 25;
        sgn  = s >>> 31;
        case (cls)
            4, 6, 8, 10, 11: imm = hi20;
            7:    imm = (32'(hi25) << 5) + 32'(ins[11:7]);
            5:    imm = (32'(sgn) << 12) + (32'(ins[7]) << 11) +
                        (32'(ins[30:25]) << 5) + (32'(ins[11:8]) << 1);
            1, 2: imm = ins & 32'hFFFF_F000;
            3:    imm = (32'(sgn) << 20) + (32'(ins[19:12]) << 12) +
                        (32'(ins[20]) << 11) + (32'(ins[30:21]) << 1);
            default: imm = 32'd0;
        endcase
        b.pc   = pc;
        b.cls  = 4'(cls);
        b.rd   = (cls == 0 || cls == 5 || cls == 7) ? 5'd0 : ins[11:7];
        b.rs1  = ins[19:15];
        b.rs2  = ins[24:20];
        b.f3   = ins[14:12];
        b.f7b5 = ins[30];
        b.imm  = imm;
        b.ill  = (cls == 0);
        return b;
    endfunction

    function automatic beat_t dut_beat();
        return {bus.d_pc, bus.d_class, bus.d_rd, bus.d_rs1, bus.d_rs2,
                bus.d_funct3, bus.d_funct7b5, bus.d_imm, bus.d_illegal};
    endfunction

    // Monitor: samples handshakes on the falling edge, ahead of the rising edge that acts on them.
    always @(negedge clk) begin
        beat_t cur, e;
        acc_flag = 0;
        if (!rst_n) begin
            exp_q.delete();
            hold = 0;
        end else begin
            cur = dut_beat();
            if (hold && bus.d_valid) begin
                tests++;
                if (cur !== held) begin
                    fails++;
                    $display("FAIL hold_stable got=%h exp=%h", cur, held);
                end
            end
            hold = 0;
            if (c_flush) begin
                exp_q.delete();
                acc_flag = bus.f_valid && bus.f_ready;
            end else begin
                if (bus.d_valid && bus.d_ready) begin
                    take_count++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL extra_beat got=%h exp=none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            fails++;
                            $display("FAIL beat pc=%h got=%h exp=%h", e.pc, cur, e);
                        end
                    end
                end else if (bus.d_valid) begin
                    hold = 1;
                    held = cur;
                end
                if (bus.f_valid && bus.f_ready) begin
                    exp_q.push_back(model(bus.f_instr, bus.f_pc));
                    acc_count++;
                    acc_flag = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.d_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] ins);
        bus.f_valid = 1'b1;
        bus.f_instr = ins;
        bus.f_pc    = pc_next;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (acc_flag) begin
                bus.f_valid = 1'b0;
                pc_next += 32'd4;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL send_timeout got=no_accept exp=accept instr=%h", ins);
        bus.f_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [11];
        logic [31:0] w;
        logic [6:0] op;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        op = opcs[$urandom_range(0, 10)];
        w[6:0] = op;
        if ((op == 7'h33 || op == 7'h13) && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 2))
                0:       w[31:25] = 7'h00;
                1:       w[31:25] = 7'h20;
                default: w[31:25] = 7'h01;
            endcase
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_take;
        int idx;
        logic [31:0] bp [6];

        bus.f_valid = 1'b0;
        bus.f_pc    = '0;
        bus.f_instr = '0;
        bus.d_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_f_ready", 32'(bus.f_ready), 32'd1);
        check("reset_d_valid", 32'(bus.d_valid), 32'd0);
        check("reset_d_pc", bus.d_pc, 32'd0);
        check("reset_d_imm", bus.d_imm, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // addi then beq with execute ready: one-cycle latency.
        bus.d_ready = 1'b1;
        send(32'h0050_0093);
        check("addi_latency_valid", 32'(bus.d_valid), 32'd1);
        check("addi_imm", bus.d_imm, 32'h0000_0005);
        send(32'hFE00_0EE3);
        check("beq_imm", bus.d_imm, 32'hFFFF_FFFC);
        check("beq_rd", 32'(bus.d_rd), 32'd0);
        tick();

        // Illegal encodings and the M-extension multiply.
        send(32'h0000_0000);
        send(32'h0000_3003);
        send(32'h0220_8033);
        repeat (3) tick();

        // Backpressure: 6 back-to-back beats, execute stalled for 3 cycles.
        bus.d_ready = 1'b0;
        for (int i = 0; i < 6; i++) bp[i] = rand_instr();
        base_acc  = acc_count;
        base_take = 0;
        idx = 0;
        bus.f_valid = 1'b1;
        bus.f_instr = bp[0];
        bus.f_pc    = pc_next;
        for (int cyc = 0; cyc < 9; cyc++) begin
            tick();
            if (acc_flag) begin
                idx++;
                pc_next += 32'd4;
                if (idx < 6) begin
                    bus.f_instr = bp[idx];
                    bus.f_pc    = pc_next;
                end else begin
                    bus.f_valid = 1'b0;
                end
            end
            if (cyc == 2) begin
                check("bp_two_accepts", 32'(acc_count - base_acc), 32'd2);
                check("bp_f_ready_low", 32'(bus.f_ready), 32'd0);
                bus.d_ready = 1'b1;
                base_take = take_count;
            end
        end
        check("bp_no_gaps", 32'(take_count - base_take), 32'd6);
        check("bp_all_sent", 32'(idx), 32'd6);
        bus.f_valid = 1'b0;
        repeat (2) tick();

        // Flush while both entries are full, with a beat offered alongside.
        bus.d_ready = 1'b0;
        send(32'h0010_0113);
        send(32'h0020_0193);
        check("flush_pre_full", 32'(bus.f_ready), 32'd0);
        bus.f_valid = 1'b1;
        bus.f_instr = 32'h0030_0213;
        bus.f_pc    = 32'hDEAD_0000;
        c_flush     = 1'b1;
        tick();
        c_flush     = 1'b0;
        bus.f_valid = 1'b0;
        check("flush_d_valid", 32'(bus.d_valid), 32'd0);
        check("flush_f_ready", 32'(bus.f_ready), 32'd1);
        bus.d_ready = 1'b1;
        tick();
        check("flush_no_ghost", 32'(bus.d_valid), 32'd0);
        tick();

        // Asynchronous reset while full: outputs clear without a clock edge.
        bus.d_ready = 1'b0;
        send(32'h1234_5037);
        send(32'h0080_006F);
        #2 rst_n = 1'b0;
        #1;
        check("areset_d_valid", 32'(bus.d_valid), 32'd0);
        check("areset_f_ready", 32'(bus.f_ready), 32'd1);
        check("areset_d_pc", bus.d_pc, 32'd0);
        check("areset_d_class", 32'(bus.d_class), 32'd0);
        check("areset_d_imm", bus.d_imm, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Randomized traffic with random execute stalls and fetch gaps.
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send(rand_instr());
        end
        rand_ready = 0;
        bus.d_ready = 1'b1;
        repeat (6) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
